// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard, optional same-cycle writeback
// bypass and a registered debug read port. Register 0 is hardwired to zero.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 4,
    parameter int NWRITE = 2,
    parameter int NISSUE = 2,
    parameter int BYPASS = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREAD*$clog2(DEPTH)-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0]            rd_data,
    output logic [NREAD-1:0]                  rd_ready,
    input  logic [NWRITE-1:0]                 wr_ena,
    input  logic [NWRITE*$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NWRITE*WIDTH-1:0]           wr_data,
    input  logic [NISSUE-1:0]                 iss_ena,
    input  logic [NISSUE*$clog2(DEPTH)-1:0]   iss_addr,
    input  logic                              flush,
    input  logic [$clog2(DEPTH)-1:0]          dbg_addr,
    output logic [WIDTH-1:0]                  dbg_data,
    output logic [$clog2(DEPTH):0]            busy_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;
    logic [WIDTH-1:0] dbg_data_q;
    logic [WIDTH-1:0] dbg_data_d;

    logic [AW-1:0]    wa;
    logic [AW-1:0]    ia;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    ba;

    // Ascending port order lets the highest-index writer overwrite the others.
    always_comb begin
        mem_d = mem_q;
        wa    = '0;
        for (int w = 0; w < NWRITE; w++) begin
            wa = wr_addr[w*AW +: AW];
            if (wr_ena[w] && wa != '0) begin
                mem_d[wa] = wr_data[w*WIDTH +: WIDTH];
            end
        end
        mem_d[0] = '0;
    end

    // Clears are applied before sets so a same-cycle claim wins the race.
    always_comb begin
        busy_d = busy_q;
        ia     = '0;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                ia = wr_addr[w*AW +: AW];
                if (wr_ena[w]) begin
                    busy_d[ia] = 1'b0;
                end
            end
            for (int k = 0; k < NISSUE; k++) begin
                ia = iss_addr[k*AW +: AW];
                if (iss_ena[k] && ia != '0) begin
                    busy_d[ia] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Debug tap samples the pre-write contents; no forwarding.
    always_comb begin
        dbg_data_d = '0;
        if (dbg_addr != '0) begin
            dbg_data_d = mem_q[dbg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            dbg_data_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Read ports see the current storage/scoreboard, overridden by any
    // same-cycle writeback when forwarding is enabled.
    always_comb begin
        rd_data  = '0;
        rd_ready = '1;
        ra       = '0;
        ba       = '0;
        for (int r = 0; r < NREAD; r++) begin
            ra = rd_addr[r*AW +: AW];
            if (ra != '0) begin
                rd_data[r*WIDTH +: WIDTH] = mem_q[ra];
                rd_ready[r]               = ~busy_q[ra];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWRITE; w++) begin
                        ba = wr_addr[w*AW +: AW];
                        if (wr_ena[w] && ba == ra) begin
                            rd_data[r*WIDTH +: WIDTH] = wr_data[w*WIDTH +: WIDTH];
                            rd_ready[r]               = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign dbg_data = dbg_data_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance (bypass on) and a DEPTH=16/NREAD=6/
// NWRITE=3/no-bypass instance, both checked every cycle against an array model.
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    logic [19:0]  a_rd_addr;
    logic [127:0] a_rd_data;
    logic [3:0]   a_rd_ready;
    logic [1:0]   a_wr_ena;
    logic [9:0]   a_wr_addr;
    logic [63:0]  a_wr_data;
    logic [1:0]   a_iss_ena;
    logic [9:0]   a_iss_addr;
    logic         a_flush;
    logic [4:0]   a_dbg_addr;
    logic [31:0]  a_dbg_data;
    logic [5:0]   a_busy_cnt;

    logic [23:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [5:0]   b_rd_ready;
    logic [2:0]   b_wr_ena;
    logic [11:0]  b_wr_addr;
    logic [95:0]  b_wr_data;
    logic [1:0]   b_iss_ena;
    logic [7:0]   b_iss_addr;
    logic         b_flush;
    logic [3:0]   b_dbg_addr;
    logic [31:0]  b_dbg_data;
    logic [4:0]   b_busy_cnt;

    regfile_sb dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
        .wr_ena(a_wr_ena), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_ena(a_iss_ena), .iss_addr(a_iss_addr), .flush(a_flush),
        .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .busy_cnt(a_busy_cnt)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(16), .NREAD(6), .NWRITE(3), .NISSUE(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
        .wr_ena(b_wr_ena), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_ena(b_iss_ena), .iss_addr(b_iss_addr), .flush(b_flush),
        .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .busy_cnt(b_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per instance [inst][port]
    logic [4:0]  s_rd_addr  [2][6];
    logic        s_wr_ena   [2][3];
    logic [4:0]  s_wr_addr  [2][3];
    logic [31:0] s_wr_data  [2][3];
    logic        s_iss_ena  [2][2];
    logic [4:0]  s_iss_addr [2][2];
    logic        s_flush    [2];
    logic [4:0]  s_dbg_addr [2];

    always_comb begin
        a_rd_addr = '0; a_wr_ena = '0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_ena = '0; a_iss_addr = '0;
        b_rd_addr = '0; b_wr_ena = '0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_ena = '0; b_iss_addr = '0;
        for (int p = 0; p < 4; p++) a_rd_addr[p*5 +: 5] = s_rd_addr[0][p];
        for (int p = 0; p < 6; p++) b_rd_addr[p*4 +: 4] = s_rd_addr[1][p][3:0];
        for (int w = 0; w < 2; w++) begin
            a_wr_ena[w]           = s_wr_ena[0][w];
            a_wr_addr[w*5 +: 5]   = s_wr_addr[0][w];
            a_wr_data[w*32 +: 32] = s_wr_data[0][w];
        end
        for (int w = 0; w < 3; w++) begin
            b_wr_ena[w]           = s_wr_ena[1][w];
            b_wr_addr[w*4 +: 4]   = s_wr_addr[1][w][3:0];
            b_wr_data[w*32 +: 32] = s_wr_data[1][w];
        end
        for (int k = 0; k < 2; k++) begin
            a_iss_ena[k]         = s_iss_ena[0][k];
            a_iss_addr[k*5 +: 5] = s_iss_addr[0][k];
            b_iss_ena[k]         = s_iss_ena[1][k];
            b_iss_addr[k*4 +: 4] = s_iss_addr[1][k][3:0];
        end
        a_flush    = s_flush[0];
        b_flush    = s_flush[1];
        a_dbg_addr = s_dbg_addr[0];
        b_dbg_addr = s_dbg_addr[1][3:0];
    end

    function automatic int n_rd(input int i);  return (i == 0) ? 4 : 6;  endfunction
    function automatic int n_wr(input int i);  return (i == 0) ? 2 : 3;  endfunction
    function automatic int dep(input int i);   return (i == 0) ? 32 : 16; endfunction
    function automatic bit byp(input int i);   return (i == 0);           endfunction

    // Reference model: plain register array, busy flags, debug sample
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    logic [31:0] m_dbg  [2];

    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dbg[i] = '0;
            for (int a = 0; a < 32; a++) begin
                m_mem[i][a]  = '0;
                m_busy[i][a] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_dbg[i] = m_mem[i][s_dbg_addr[i]];
            if (s_flush[i]) begin
                for (int a = 0; a < 32; a++) m_busy[i][a] = 1'b0;
            end else begin
                for (int w = 0; w < n_wr(i); w++)
                    if (s_wr_ena[i][w]) m_busy[i][s_wr_addr[i][w]] = 1'b0;
                for (int k = 0; k < 2; k++)
                    if (s_iss_ena[i][k] && s_iss_addr[i][k] != 0) m_busy[i][s_iss_addr[i][k]] = 1'b1;
            end
            for (int w = 0; w < n_wr(i); w++)
                if (s_wr_ena[i][w] && s_wr_addr[i][w] != 0) m_mem[i][s_wr_addr[i][w]] = s_wr_data[i][w];
        end
    endtask

    task automatic exp_read(input int i, input logic [4:0] a, output logic [31:0] d, output logic r);
        d = m_mem[i][a];
        r = !m_busy[i][a];
        if (a == 0) begin
            d = '0;
            r = 1'b1;
        end else if (byp(i)) begin
            for (int w = 0; w < n_wr(i); w++) begin
                if (s_wr_ena[i][w] && s_wr_addr[i][w] == a) begin
                    d = s_wr_data[i][w];
                    r = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] rdd(input int i, input int p);
        if (i == 0) return a_rd_data[p*32 +: 32];
        return b_rd_data[p*32 +: 32];
    endfunction

    function automatic logic rdy(input int i, input int p);
        if (i == 0) return a_rd_ready[p];
        return b_rd_ready[p];
    endfunction

    task automatic compare_all();
        logic [31:0] d;
        logic        r;
        int          cnt;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < n_rd(i); p++) begin
                exp_read(i, s_rd_addr[i][p], d, r);
                chk((i == 0) ? "a_rd_data" : "b_rd_data", p, rdd(i, p), d);
                chk((i == 0) ? "a_rd_ready" : "b_rd_ready", p, 32'(rdy(i, p)), 32'(r));
            end
            cnt = 0;
            for (int a = 0; a < dep(i); a++) cnt += int'(m_busy[i][a]);
            chk((i == 0) ? "a_busy_cnt" : "b_busy_cnt", 0,
                (i == 0) ? 32'(a_busy_cnt) : 32'(b_busy_cnt), 32'(cnt));
            chk((i == 0) ? "a_dbg_data" : "b_dbg_data", 0,
                (i == 0) ? a_dbg_data : b_dbg_data, m_dbg[i]);
        end
    endtask

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 3; w++) begin
                s_wr_ena[i][w]  = 1'b0;
                s_wr_addr[i][w] = '0;
                s_wr_data[i][w] = '0;
            end
            for (int k = 0; k < 2; k++) begin
                s_iss_ena[i][k]  = 1'b0;
                s_iss_addr[i][k] = '0;
            end
            s_flush[i] = 1'b0;
        end
    endtask

    function automatic logic [4:0] rand_addr(input int d);
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, d - 1));
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 6; p++) s_rd_addr[i][p] = rand_addr(dep(i));
            for (int w = 0; w < 3; w++) begin
                s_wr_ena[i][w]  = 1'($urandom_range(0, 1));
                s_wr_addr[i][w] = rand_addr(dep(i));
                s_wr_data[i][w] = $urandom;
            end
            for (int k = 0; k < 2; k++) begin
                s_iss_ena[i][k]  = ($urandom_range(0, 2) == 0);
                s_iss_addr[i][k] = rand_addr(dep(i));
            end
            s_flush[i]    = ($urandom_range(0, 39) == 0);
            s_dbg_addr[i] = 5'($urandom_range(0, dep(i) - 1));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 6; p++) s_rd_addr[i][p] = 5'(p + 1);
            s_dbg_addr[i] = '0;
        end
        model_reset();
        #1;
        chk("rst_rd_data0", 0, rdd(0, 0), 32'h0);
        chk("rst_rd_ready", 0, 32'(a_rd_ready), 32'hF);
        chk("rst_busy_cnt", 0, 32'(a_busy_cnt), 32'h0);
        chk("rst_dbg_data", 0, a_dbg_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-operation
        s_wr_ena[0][0] = 1'b1; s_wr_addr[0][0] = 5'd5; s_wr_data[0][0] = 32'hDEADBEEF;
        s_iss_ena[0][0] = 1'b1; s_iss_addr[0][0] = 5'd6;
        s_rd_addr[0][0] = 5'd5; s_rd_addr[0][1] = 5'd6;
        #1;
        chk("t1_bypass_data", 0, rdd(0, 0), 32'hDEADBEEF);
        chk("t1_preclaim_ready", 1, 32'(rdy(0, 1)), 32'h1);
        tick();
        idle();
        #1;
        chk("t1_stored_data", 0, rdd(0, 0), 32'hDEADBEEF);
        chk("t1_claimed_ready", 1, 32'(rdy(0, 1)), 32'h0);
        chk("t1_busy_cnt", 0, 32'(a_busy_cnt), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_async_rd_data", 0, rdd(0, 0), 32'h0);
        chk("t1_async_ready", 1, 32'(rdy(0, 1)), 32'h1);
        chk("t1_async_busy_cnt", 0, 32'(a_busy_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write conflict, plus debug pre-write sampling
        s_wr_ena[0][0] = 1'b1; s_wr_addr[0][0] = 5'd3; s_wr_data[0][0] = 32'h11;
        s_wr_ena[0][1] = 1'b1; s_wr_addr[0][1] = 5'd3; s_wr_data[0][1] = 32'h22;
        s_rd_addr[0][0] = 5'd3; s_dbg_addr[0] = 5'd3;
        #1;
        chk("t2_same_cycle", 0, rdd(0, 0), 32'h22);
        tick();
        idle();
        #1;
        chk("t2_next_cycle", 0, rdd(0, 0), 32'h22);
        chk("t2_dbg_prewrite", 0, a_dbg_data, 32'h0);
        tick();
        chk("t2_dbg_late", 0, a_dbg_data, 32'h22);

        // r0 immunity
        s_iss_ena[0][1] = 1'b1; s_iss_addr[0][1] = 5'd12;
        tick();
        idle();
        s_wr_ena[0][0] = 1'b1; s_wr_addr[0][0] = 5'd0; s_wr_data[0][0] = 32'hFFFFFFFF;
        s_iss_ena[0][0] = 1'b1; s_iss_addr[0][0] = 5'd0;
        s_rd_addr[0][0] = 5'd0;
        #1;
        chk("t3_r0_data", 0, rdd(0, 0), 32'h0);
        chk("t3_r0_ready", 0, 32'(rdy(0, 0)), 32'h1);
        chk("t3_busy_before", 0, 32'(a_busy_cnt), 32'h1);
        tick();
        idle();
        #1;
        chk("t3_r0_data_after", 0, rdd(0, 0), 32'h0);
        chk("t3_busy_after", 0, 32'(a_busy_cnt), 32'h1);
        s_flush[0] = 1'b1;
        tick();
        idle();
        #1;
        chk("t3_flush_cnt", 0, 32'(a_busy_cnt), 32'h0);

        // Scoreboard timing on both instances (bypass vs storage-only)
        for (int i = 0; i < 2; i++) begin
            s_iss_ena[i][0] = 1'b1; s_iss_addr[i][0] = 5'd7; s_rd_addr[i][0] = 5'd7;
        end
        #1;
        chk("t4_a_c0_ready", 0, 32'(rdy(0, 0)), 32'h1);
        chk("t4_b_c0_ready", 0, 32'(rdy(1, 0)), 32'h1);
        tick();
        idle();
        #1;
        chk("t4_a_c1_ready", 0, 32'(rdy(0, 0)), 32'h0);
        chk("t4_b_c1_ready", 0, 32'(rdy(1, 0)), 32'h0);
        chk("t4_a_c1_cnt", 0, 32'(a_busy_cnt), 32'h1);
        chk("t4_b_c1_cnt", 0, 32'(b_busy_cnt), 32'h1);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            s_wr_ena[i][0] = 1'b1; s_wr_addr[i][0] = 5'd7; s_wr_data[i][0] = 32'h1234;
            s_dbg_addr[i] = 5'd7;
        end
        #1;
        chk("t4_a_c3_ready", 0, 32'(rdy(0, 0)), 32'h1);
        chk("t4_a_c3_data", 0, rdd(0, 0), 32'h1234);
        chk("t4_b_c3_ready", 0, 32'(rdy(1, 0)), 32'h0);
        chk("t4_b_c3_data", 0, rdd(1, 0), 32'h0);
        tick();
        idle();
        #1;
        chk("t4_a_c4_cnt", 0, 32'(a_busy_cnt), 32'h0);
        chk("t4_b_c4_cnt", 0, 32'(b_busy_cnt), 32'h0);
        chk("t4_b_c4_ready", 0, 32'(rdy(1, 0)), 32'h1);
        chk("t4_b_c4_data", 0, rdd(1, 0), 32'h1234);
        tick();
        chk("t4_a_dbg", 0, a_dbg_data, 32'h1234);
        chk("t4_b_dbg", 0, b_dbg_data, 32'h1234);

        // Set/clear race, then flush overriding a claim
        s_wr_ena[0][0] = 1'b1; s_wr_addr[0][0] = 5'd9; s_wr_data[0][0] = 32'h99;
        s_iss_ena[0][0] = 1'b1; s_iss_addr[0][0] = 5'd9;
        s_rd_addr[0][0] = 5'd9; s_rd_addr[0][1] = 5'd10;
        tick();
        idle();
        #1;
        chk("t5_race_ready", 0, 32'(rdy(0, 0)), 32'h0);
        chk("t5_race_cnt", 0, 32'(a_busy_cnt), 32'h1);
        chk("t5_race_data", 0, rdd(0, 0), 32'h99);
        s_flush[0] = 1'b1;
        s_iss_ena[0][0] = 1'b1; s_iss_addr[0][0] = 5'd10;
        tick();
        idle();
        #1;
        chk("t5_flush_cnt", 0, 32'(a_busy_cnt), 32'h0);
        chk("t5_r10_ready", 1, 32'(rdy(0, 1)), 32'h1);
        chk("t5_r9_ready", 0, 32'(rdy(0, 0)), 32'h1);

        // Random traffic on both instances, with one reset pulse in the middle
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            if (c == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
